// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: two requesters share a single bit-serial full-adder
// slice. A round-robin arbiter picks a winner, whose operands are added
// LSB-first over WIDTH cycles through a registered carry. The result is
// presented with a one-cycle valid pulse.

// Gate-level full-adder cell; the only arithmetic element in the datapath.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);
    assign s = x ^ y ^ z;
    assign c = ((x ^ y) & z) | (x & y);
endmodule

module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             valid,
    output logic             owner,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cur;
    logic             last;

    logic             take;
    logic             win;
    logic             last_bit;
    logic             fa_s;
    logic             fa_c;

    // Round-robin pick: a lone requester wins outright; on a tie the
    // requester that did not finish most recently wins.
    assign take     = req0 | req1;
    assign win      = req1 & (~req0 | ~last);
    assign last_bit = (cnt == CNT_LAST);
    assign busy     = (state != IDLE);

    // The new sum bit enters at the MSB so that after WIDTH shifts the
    // LSB-first stream sits in natural bit order.
    assign result_nxt = {fa_s, result[WIDTH-1:1]};

    full_adder_cell u_fa (
        .x (a_sh[0]),
        .y (b_sh[0]),
        .z (carry),
        .s (fa_s),
        .c (fa_c)
    );

    // Operand shifters, carry and partial result: load on capture, shift in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a_sh   <= win ? a1 : a0;
                        b_sh   <= win ? b1 : b0;
                        carry  <= win ? cin1 : cin0;
                        result <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_c;
                    result <= result_nxt;
                end
                default: ;
            endcase
        end
    end

    // Sequencer: arbitration, bit counter, grant/valid pulses and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= 1'b0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            valid <= 1'b0;
            owner <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        cur   <= win;
                        cnt   <= '0;
                        gnt0  <= ~win;
                        gnt1  <= win;
                        state <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (last_bit) begin
                        sum   <= result_nxt;
                        cout  <= fa_c;
                        owner <= cur;
                        valid <= 1'b1;
                        last  <= cur;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: expected results are queued
// at capture and compared whenever the DUT raises valid.
module tb_serial_add_arbiter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0;
    logic [W-1:0] a0 = '0;
    logic [W-1:0] b0 = '0;
    logic         cin0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] a1 = '0;
    logic [W-1:0] b1 = '0;
    logic         cin1 = 1'b0;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         valid;
    logic         owner;
    logic [W-1:0] sum;
    logic         cout;

    int n_chk  = 0;
    int n_pass = 0;

    // {owner, cout, sum}
    logic [W+1:0] exp_q[$];

    serial_add_arbiter #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .cin0  (cin0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .cin1  (cin1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .busy  (busy),
        .valid (valid),
        .owner (owner),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    task automatic push_exp(input logic own, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci);
        exp_q.push_back({own, model_add(a, b, ci)});
    endtask

    task automatic wait_gnt(output logic g0, output logic g1);
        g0 = 1'b0;
        g1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (gnt0 | gnt1) begin
                g0 = gnt0;
                g1 = gnt1;
                return;
            end
        end
        check_eq("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) return;
        end
        check_eq("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_op(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci);
        logic g0, g1;
        int lat;
        logic [W:0] t;
        t = model_add(a, b, ci);
        if (idx) begin
            req1 = 1'b1; a1 = a; b1 = b; cin1 = ci;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; cin0 = ci;
        end
        wait_gnt(g0, g1);
        check_eq("gnt_sel", 32'({g1, g0}), idx ? 32'd2 : 32'd1);
        if (g0 | g1) push_exp(idx, a, b, ci);
        req0 = 1'b0;
        req1 = 1'b0;
        check_eq("busy_run", 32'(busy), 32'd1);
        wait_valid(lat);
        check_eq("latency", 32'(lat), 32'(W));
        @(posedge clk);
        #1;
        check_eq("valid_pulse", 32'(valid), 32'd0);
        check_eq("sum_hold", 32'(sum), 32'(t[W-1:0]));
        check_eq("cout_hold", 32'(cout), 32'(t[W]));
    endtask

    // Scoreboard and grant-exclusivity monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (!rst) begin
            if (gnt0 | gnt1) check_eq("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("result", 32'({owner, cout, sum}), 32'(e));
                end
            end
        end
    end

    initial begin
        logic g0, g1;
        int lat;
        int cyc;

        // Reset state
        do_reset();
        check_eq("rst_gnt0", 32'(gnt0), 32'd0);
        check_eq("rst_gnt1", 32'(gnt1), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_out", 32'({owner, cout, sum}), 32'd0);

        // Single requesters
        run_op(1'b0, 8'h0F, 8'h01, 1'b0);
        run_op(1'b1, 8'hFF, 8'h01, 1'b0);

        // Simultaneous requests from reset: req0 first, then alternate
        do_reset();
        req0 = 1'b1; a0 = 8'h55; b0 = 8'hAA; cin0 = 1'b1;
        req1 = 1'b1; a1 = 8'h03; b1 = 8'h04; cin1 = 1'b0;
        wait_gnt(g0, g1);
        check_eq("rr_first", 32'({g1, g0}), 32'd1);
        push_exp(1'b0, 8'h55, 8'hAA, 1'b1);
        req0 = 1'b0;
        wait_valid(lat);
        check_eq("rr_lat0", 32'(lat), 32'(W));
        wait_gnt(g0, g1);
        check_eq("rr_second", 32'({g1, g0}), 32'd2);
        push_exp(1'b1, 8'h03, 8'h04, 1'b0);
        req1 = 1'b0;
        wait_valid(lat);
        check_eq("rr_lat1", 32'(lat), 32'(W));
        req0 = 1'b1; a0 = 8'h01; b0 = 8'h02; cin0 = 1'b0;
        req1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1;
        wait_gnt(g0, g1);
        check_eq("rr_third", 32'({g1, g0}), 32'd1);
        push_exp(1'b0, 8'h01, 8'h02, 1'b0);
        req0 = 1'b0;
        wait_valid(lat);
        wait_gnt(g0, g1);
        check_eq("rr_fourth", 32'({g1, g0}), 32'd2);
        push_exp(1'b1, 8'h80, 8'h80, 1'b1);
        req1 = 1'b0;
        wait_valid(lat);
        @(posedge clk);
        #1;

        // Full carry chain
        run_op(1'b0, 8'hFF, 8'hFF, 1'b1);

        // Reset after the third RUN edge aborts the op
        req0 = 1'b1; a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0;
        wait_gnt(g0, g1);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_valid", 32'(valid), 32'd0);
        check_eq("abort_gnt", 32'({gnt1, gnt0}), 32'd0);
        check_eq("abort_out", 32'({owner, cout, sum}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
        check_eq("abort_sum_kept", 32'(sum), 32'd0);
        run_op(1'b1, 8'h10, 8'h20, 1'b0);

        // req1 raised mid-RUN waits for the IDLE edge after DONE
        req0 = 1'b1; a0 = 8'h21; b0 = 8'h43; cin0 = 1'b1;
        wait_gnt(g0, g1);
        check_eq("mid_gnt0", 32'({g1, g0}), 32'd1);
        push_exp(1'b0, 8'h21, 8'h43, 1'b1);
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        req1 = 1'b1; a1 = 8'hC0; b1 = 8'h7F; cin1 = 1'b1;
        cyc = 3;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (gnt1) break;
        end
        check_eq("gnt_period", 32'(cyc), 32'(W + 2));
        if (gnt1) push_exp(1'b1, 8'hC0, 8'h7F, 1'b1);
        req1 = 1'b0;
        wait_valid(lat);
        check_eq("mid_lat", 32'(lat), 32'(W));
        repeat (3) @(posedge clk);
        #1;
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_add_arbiter.md
Name: serial_add_arbiter

Overview:
- Shares one bit-serial full-adder slice between two requesters.
- Round-robin arbitration; the winner's operands are captured and added LSB-first over WIDTH cycles through a registered carry.
- Result (sum, carry-out, owner) is returned with a one-cycle valid pulse.
- Sits between two client blocks and the gate-level full-adder cell, trading latency for area.

Parameters:
- WIDTH, 8, operand and sum width in bits (>= 2)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request, held until gnt0
- a0  input  WIDTH  requester 0 operand A
- b0  input  WIDTH  requester 0 operand B
- cin0  input  1  requester 0 carry-in
- req1  input  1  requester 1 request, held until gnt1
- a1  input  WIDTH  requester 1 operand A
- b1  input  WIDTH  requester 1 operand B
- cin1  input  1  requester 1 carry-in
- gnt0  output  1  one-cycle pulse: requester 0 operands captured
- gnt1  output  1  one-cycle pulse: requester 1 operands captured
- busy  output  1  high whenever state != IDLE
- valid  output  1  one-cycle pulse: sum/cout/owner updated
- owner  output  1  index of the requester whose result is on sum/cout
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  bit WIDTH of a + b + cin

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, gnt0=gnt1=busy=valid=0, owner=0, sum=0, cout=0, shift/carry/counter regs=0, priority pointer last=1 (req0 wins first).
- States: IDLE, RUN, DONE.
- IDLE: req0/req1 are sampled on each edge.
  - Only one asserted: that requester wins.
  - Both asserted: winner = !last.
  - On the winning edge (capture edge E0):
    - A_sh <= a_w, B_sh <= b_w, carry <= cin_w, cnt <= 0, cur <= w.
    - Next state RUN.
    - gnt_w = 1 for the following cycle only.
- RUN: each edge:
  - s = A_sh[0]^B_sh[0]^carry.
  - carry <= A_sh[0]&B_sh[0] | (A_sh[0]^B_sh[0])&carry.
  - A_sh, B_sh shift right (zero fill).
  - s is shifted into the MSB of the result register.
  - cnt++.
  - At the edge where cnt == WIDTH-1 (edge E_WIDTH), the last bit is processed and the state goes to DONE.
- DONE: the outputs are loaded at edge E_WIDTH:
  - sum = result, cout = carry, owner = cur.
  - valid = 1 during the DONE cycle only.
  - last <= cur.
  - Next edge: state goes to IDLE.
- Latency: valid rises WIDTH edges after the capture edge. Next capture is no earlier than edge E_WIDTH+2, so throughput is one op per WIDTH+2 cycles.
- Requests during RUN/DONE are ignored (not queued). A requester keeps req and operands stable until its gnt. Operands may change after gnt.
- sum/cout/owner hold their value between valid pulses. An aborted op never updates them.
- gnt0 and gnt1 are never high in the same cycle. Exactly one gnt is issued per captured op.
- Reset mid-RUN or mid-DONE aborts immediately: all outputs return to their reset values, no valid is issued, and last returns to 1.
- The per-bit logic is the gate-level full-adder cell (S = x^y^z, C = (x^y)z | xy) instantiated once. No WIDTH-bit adder is permitted.

Test Plan:
1. Reset, then req0 with a0=8'h0F, b0=8'h01, cin0=0.
   -> gnt0 pulses 1 cycle after capture; busy high.
   -> valid 8 edges after capture with sum=8'h10, cout=0, owner=0.
2. req1 only, a1=8'hFF, b1=8'h01, cin1=0 -> gnt1 only; sum=8'h00, cout=1, owner=1.
3. From reset, req0 (a=8'h55, b=8'hAA, cin=1) and req1 (a=8'h03, b=8'h04, cin=0) asserted together and held until their gnt.
   -> First op: owner=0, sum=8'h00, cout=1.
   -> Second op: owner=1, sum=8'h07, cout=0.
   -> Both re-asserted -> req0 wins again.
4. req0 with a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Valid is exactly one cycle; sum holds afterwards.
5. rst pulsed after the 3rd RUN edge.
   -> Immediately all outputs 0, busy=0, no valid.
   -> Subsequent req1 (8'h10+8'h20) yields sum=8'h30, owner=1.
6. req1 raised mid-RUN of a req0 op.
   -> No gnt1 until the IDLE cycle after DONE.
   -> Captured on that edge; period check is WIDTH+2 cycles between gnt pulses.
